i2c_eeprom_target: RTL and testbench
====================================

// Module: i2c_eeprom_target
// PURPOSE
//  I2C target (responder) emulating a 24Cxx-style EEPROM: 7-bit address match, 8-bit word pointer,
//  sequential write/read of an internal byte array. Counterpart of the axili2ccpu I2C master;
//  used as on-chip loopback target and bench peer. SCL is never stretched; o_i2c_scl is tied high.
// PARAMETERS
//  TARGET_ADDR  7'h50  7-bit I2C address answered by this target
//  MEM_DEPTH    256    bytes in array; power of two, <=256; pointer wraps modulo MEM_DEPTH
// PORTS
//  S_AXI_ACLK     in   1  system clock (>=8x SCL rate)
//  S_AXI_ARESETN  in   1  synchronous active-low reset
//  i_i2c_sda      in   1  SDA line sample (asynchronous)
//  i_i2c_scl      in   1  SCL line sample (asynchronous)
//  o_i2c_sda      out  1  SDA open-drain drive: 0 = pull low, 1 = release
//  o_i2c_scl      out  1  SCL open-drain drive; constant 1
//  o_busy         out  1  1 from addressed START (match) until STOP/NACK-exit
//  o_ptr          out  8  current word pointer
//  M_AXIS_TVALID/TREADY/TDATA[7:0]/TLAST  only with I2C_TGT_AXIS_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: o_i2c_sda=1, o_i2c_scl=1, o_busy=0, o_ptr=0, state IDLE, M_AXIS_TVALID=0. Array not reset.
//  - Inputs pass 2-FF synchronizer; edges detected on synced values (2-cycle input latency).
//  - START: SDA fall while SCL high; STOP: SDA rise while SCL high. Both override any state.
//    START (incl. repeated) -> ADDR, bit counter=0, SDA released. STOP -> IDLE, SDA released, o_busy=0.
//  - Bits sampled on SCL rise, MSB first; SDA output changes only on SCL fall (+1 clk).
//  - States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE.
//  - ADDR: 8 bits {addr[6:0],rw}. addr==TARGET_ADDR -> drive SDA=0 on 8th SCL fall, release on 9th fall;
//    o_busy=1. Mismatch -> IGNORE (no ACK, SDA released) until next START/STOP.
//  - rw=0 -> PTR: 8 bits loaded into o_ptr (upper bits masked to log2(MEM_DEPTH)), ACK -> WDATA.
//  - WDATA: each byte written to mem[o_ptr] at 8th SCL rise, ACKed, o_ptr<=o_ptr+1 (wrap).
//  - rw=1 -> after ACK released, byte mem[o_ptr] loaded; bit7 driven on 9th SCL fall, further bits
//    on following falls; o_ptr+1 when byte loaded. On 8th data bit's SCL fall SDA released -> RACK_WAIT.
//  - RACK_WAIT: sample on 9th SCL rise: 0 (ACK) -> next byte (RDATA); 1 (NACK) -> IGNORE, o_busy held
//    until STOP or repeated START.
//  - Read without prior pointer write continues from current o_ptr (current-address read).
//  - Write of pointer then repeated START + rw=1 = random read from that pointer.
//  - Pointer wrap: MEM_DEPTH-1 -> 0 for both reads and writes; no NACK on wrap.
//  - Reset mid-transfer: immediate return to reset values; SDA released same clock edge.
// CONFIGURATION
//  I2C_TGT_AXIS_EN defined: each written data byte (not pointer) presented on M_AXIS_TDATA with
//   TVALID=1 1 clk after 8th SCL rise; TLAST=1 on a zero-data beat issued at STOP ending a write.
//   Holding buffer 1 deep; if TVALID still pending when next byte arrives, byte is NACKed and
//   not written to memory. TVALID drops on TVALID&&TREADY.
//  Undefined: M_AXIS ports absent; all written bytes ACKed.
// TESTING
//  1 Write 0xA0,0x10,0x11,0x22,0x33,STOP -> three ACKs+addr/ptr ACKs; mem[0x10..12]=11,22,33; o_ptr=0x13.
//  2 Write 0xA0,0x10, Sr, 0xA1, read 3 bytes ACK,ACK,NACK, STOP -> SDA returns 11,22,33; o_ptr=0x13; o_busy=0 after STOP.
//  3 START, 0xA2 (addr 0x51) -> no ACK on 9th bit, SDA stays 1 until STOP; memory, o_ptr unchanged.
//  4 Ptr 0xFF, write 0xAA,0xBB -> mem[0xFF]=AA, mem[0x00]=BB, o_ptr=0x01 (wrap).
//  5 Assert S_AXI_ARESETN=0 mid read byte while SDA driven low -> SDA released next clk, o_busy=0, o_ptr=0.
//  6 (I2C_TGT_AXIS_EN, TREADY=0) write 0x5A,0x6B -> 0x5A ACKed & on TDATA; 0x6B NACKed, mem unchanged; then TREADY=1, STOP -> TLAST beat.

Source files
------------

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a 24Cxx-style EEPROM with 8-bit word pointer.
// Optional AXI-Stream tap of written bytes: define I2C_TGT_AXIS_EN.
module i2c_eeprom_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         MEM_DEPTH   = 256
) (
  input  logic       S_AXI_ACLK,
  input  logic       S_AXI_ARESETN,
  input  logic       i_i2c_sda,
  input  logic       i_i2c_scl,
  output logic       o_i2c_sda,
  output logic       o_i2c_scl,
  output logic       o_busy,
  output logic [7:0] o_ptr
`ifdef I2C_TGT_AXIS_EN
  ,
  output logic       M_AXIS_TVALID,
  input  logic       M_AXIS_TREADY,
  output logic [7:0] M_AXIS_TDATA,
  output logic       M_AXIS_TLAST
`endif
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [7:0] PMASK = 8'(MEM_DEPTH - 1);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK_WAIT, IGNORE
  } state_t;

  state_t      state, state_n;
  logic        phase, phase_n;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  ptr, ptr_n;
  logic        busy, busy_n;
  logic        sda_o, sda_n;
  logic        rw, rw_n;
  logic        nack, nack_n;
  logic        mem_we;
  logic [7:0]  byte_in;
  logic [7:0]  mem_rd;
  logic [7:0]  ptr_inc;
  logic        full;

  logic [7:0]  mem [MEM_DEPTH];

  logic scl_m, scl_s, scl_q;
  logic sda_m, sda_s, sda_q;
  logic scl_rise, scl_fall, start, stop;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_q <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_m <= i_i2c_scl;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= i_i2c_sda;
      sda_s <= sda_m;
      sda_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start = scl_s & scl_q & sda_q & ~sda_s;
  assign stop  = scl_s & scl_q & ~sda_q & sda_s;

  assign byte_in = {shreg[6:0], sda_s};
  assign mem_rd  = mem[ptr[AW-1:0]];
  assign ptr_inc = (ptr + 8'd1) & PMASK;

  assign o_i2c_sda = sda_o;
  assign o_i2c_scl = 1'b1;
  assign o_busy    = busy;
  assign o_ptr     = ptr;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state <= IDLE;
      phase <= 1'b0;
      cnt   <= 4'd0;
      shreg <= 8'd0;
      ptr   <= 8'd0;
      busy  <= 1'b0;
      sda_o <= 1'b1;
      rw    <= 1'b0;
      nack  <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
      ptr   <= ptr_n;
      busy  <= busy_n;
      sda_o <= sda_n;
      rw    <= rw_n;
      nack  <= nack_n;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (mem_we) mem[ptr[AW-1:0]] <= byte_in;
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    shreg_n = shreg;
    ptr_n   = ptr;
    busy_n  = busy;
    sda_n   = sda_o;
    rw_n    = rw;
    nack_n  = nack;
    mem_we  = 1'b0;
    if (start) begin
      state_n = ADDR;
      cnt_n   = 4'd0;
      phase_n = 1'b0;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else if (stop) begin
      state_n = IDLE;
      sda_n   = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        ADDR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            if (byte_in[7:1] == TARGET_ADDR) begin
              state_n = ADDR_ACK;
              phase_n = 1'b0;
              busy_n  = 1'b1;
              rw_n    = byte_in[0];
            end else begin
              state_n = IGNORE;
            end
          end
        end
        ADDR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = 1'b0;
            phase_n = 1'b1;
          end else if (rw) begin
            // first read byte goes out on the same fall that ends the ACK
            shreg_n = mem_rd;
            sda_n   = mem_rd[7];
            ptr_n   = ptr_inc;
            cnt_n   = 4'd0;
            state_n = RDATA;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
            state_n = PTR;
          end
        end
        PTR: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            ptr_n   = byte_in & PMASK;
            state_n = PTR_ACK;
            phase_n = 1'b0;
          end
        end
        PTR_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = 1'b0;
            phase_n = 1'b1;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
            state_n = WDATA;
          end
        end
        WDATA: if (scl_rise) begin
          shreg_n = byte_in;
          cnt_n   = cnt + 4'd1;
          if (cnt == 4'd7) begin
            nack_n  = full;
            mem_we  = ~full;
            if (!full) ptr_n = ptr_inc;
            state_n = WDATA_ACK;
            phase_n = 1'b0;
          end
        end
        WDATA_ACK: if (scl_fall) begin
          if (!phase) begin
            sda_n   = nack;
            phase_n = 1'b1;
          end else begin
            sda_n   = 1'b1;
            cnt_n   = 4'd0;
            state_n = WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) cnt_n = cnt + 4'd1;
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              sda_n   = 1'b1;
              phase_n = 1'b0;
              state_n = RACK_WAIT;
            end else begin
              shreg_n = {shreg[6:0], 1'b0};
              sda_n   = shreg[6];
            end
          end
        end
        RACK_WAIT: begin
          if (scl_rise) begin
            if (sda_s) state_n = IGNORE;
            else       phase_n = 1'b1;
          end else if (scl_fall && phase) begin
            shreg_n = mem_rd;
            sda_n   = mem_rd[7];
            ptr_n   = ptr_inc;
            cnt_n   = 4'd0;
            state_n = RDATA;
          end
        end
        IDLE, IGNORE: ;
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef I2C_TGT_AXIS_EN
  logic       tv, tl, lp, wr_txn;
  logic [7:0] td;

  assign full = tv & ~M_AXIS_TREADY;
  assign M_AXIS_TVALID = tv;
  assign M_AXIS_TDATA  = td;
  assign M_AXIS_TLAST  = tl;

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_txn <= 1'b0;
    end else if (start || stop) begin
      wr_txn <= 1'b0;
    end else if (state == PTR_ACK) begin
      wr_txn <= 1'b1;
    end
  end

  // lp holds a pending end-of-write marker until the buffer frees up
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      tv <= 1'b0;
      tl <= 1'b0;
      td <= 8'd0;
      lp <= 1'b0;
    end else begin
      if (tv && M_AXIS_TREADY) begin
        tv <= 1'b0;
        tl <= 1'b0;
      end
      if (stop && wr_txn) lp <= 1'b1;
      if (mem_we) begin
        tv <= 1'b1;
        td <= byte_in;
        tl <= 1'b0;
      end else if (lp && (!tv || M_AXIS_TREADY)) begin
        tv <= 1'b1;
        td <= 8'd0;
        tl <= 1'b1;
        lp <= 1'b0;
      end
    end
  end
`else
  assign full = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_eeprom_target.sv
// Directed bench for i2c_eeprom_target acting as an I2C master peer.
// Covers write, random/current read, address miss, wrap and reset.
module tb_i2c_eeprom_target;

  localparam time Q = 80;

  logic       clk;
  logic       rst_n;
  logic       sda_m;
  logic       scl_m;
  logic       sda_line;
  logic       o_i2c_sda;
  logic       o_i2c_scl;
  logic       o_busy;
  logic [7:0] o_ptr;
  int         n_cmp;
  int         n_bad;

`ifdef I2C_TGT_AXIS_EN
  logic       tvalid;
  logic       tready;
  logic [7:0] tdata;
  logic       tlast;
`endif

  assign sda_line = sda_m & o_i2c_sda;

  i2c_eeprom_target dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .i_i2c_sda    (sda_line),
    .i_i2c_scl    (scl_m),
    .o_i2c_sda    (o_i2c_sda),
    .o_i2c_scl    (o_i2c_scl),
    .o_busy       (o_busy),
    .o_ptr        (o_ptr)
`ifdef I2C_TGT_AXIS_EN
    ,
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TREADY(tready),
    .M_AXIS_TDATA (tdata),
    .M_AXIS_TLAST (tlast)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    sda_m = b;
    #Q;
    scl_m = 1'b1;
    #Q;
    r = sda_line;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    #Q;
    scl_m = 1'b1;
    #Q;
    sda_m = 1'b1;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(mack, r);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    n_cmp = 0;
    n_bad = 0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    rst_n = 1'b0;
`ifdef I2C_TGT_AXIS_EN
    tready = 1'b0;
`endif
    repeat (4) @(negedge clk);
    chk("rst_sda", {7'd0, o_i2c_sda}, 8'h01);
    chk("rst_scl", {7'd0, o_i2c_scl}, 8'h01);
    chk("rst_busy", {7'd0, o_busy}, 8'h00);
    chk("rst_ptr", o_ptr, 8'h00);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // sequential write 11,22,33 from 0x10
    i2c_start();
    wr_byte(8'hA0, ack); chk("t1_ack_addr", {7'd0, ack}, 8'h00);
    chk("t1_busy", {7'd0, o_busy}, 8'h01);
    wr_byte(8'h10, ack); chk("t1_ack_ptr", {7'd0, ack}, 8'h00);
    wr_byte(8'h11, ack); chk("t1_ack_d0", {7'd0, ack}, 8'h00);
    wr_byte(8'h22, ack); chk("t1_ack_d1", {7'd0, ack}, 8'h00);
    wr_byte(8'h33, ack); chk("t1_ack_d2", {7'd0, ack}, 8'h00);
    i2c_stop();
    chk("t1_ptr", o_ptr, 8'h13);
    chk("t1_busy_end", {7'd0, o_busy}, 8'h00);

    // random read of three bytes from 0x10
    i2c_start();
    wr_byte(8'hA0, ack); chk("t2_ack_addr", {7'd0, ack}, 8'h00);
    wr_byte(8'h10, ack); chk("t2_ack_ptr", {7'd0, ack}, 8'h00);
    i2c_start();
    wr_byte(8'hA1, ack); chk("t2_ack_raddr", {7'd0, ack}, 8'h00);
    rd_byte(1'b0, d); chk("t2_rd0", d, 8'h11);
    rd_byte(1'b0, d); chk("t2_rd1", d, 8'h22);
    rd_byte(1'b1, d); chk("t2_rd2", d, 8'h33);
    chk("t2_busy_held", {7'd0, o_busy}, 8'h01);
    chk("t2_sda_rel", {7'd0, o_i2c_sda}, 8'h01);
    i2c_stop();
    chk("t2_busy_end", {7'd0, o_busy}, 8'h00);
    chk("t2_ptr", o_ptr, 8'h13);

    // address 0x51 is ignored
    i2c_start();
    wr_byte(8'hA2, ack); chk("t3_nack_addr", {7'd0, ack}, 8'h01);
    chk("t3_busy", {7'd0, o_busy}, 8'h00);
    wr_byte(8'h00, ack); chk("t3_nack_byte", {7'd0, ack}, 8'h01);
    i2c_stop();
    chk("t3_ptr", o_ptr, 8'h13);

    // pointer-only write, then current-address read
    i2c_start();
    wr_byte(8'hA0, ack); chk("t3b_ack", {7'd0, ack}, 8'h00);
    wr_byte(8'h11, ack); chk("t3b_ack_ptr", {7'd0, ack}, 8'h00);
    i2c_stop();
    i2c_start();
    wr_byte(8'hA1, ack); chk("t3b_ack_rd", {7'd0, ack}, 8'h00);
    rd_byte(1'b1, d); chk("t3b_cur_rd", d, 8'h22);
    i2c_stop();
    chk("t3b_ptr", o_ptr, 8'h12);

    // pointer wrap on write and on read
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'hFF, ack);
    wr_byte(8'hAA, ack); chk("t4_ack_aa", {7'd0, ack}, 8'h00);
    wr_byte(8'hBB, ack); chk("t4_ack_bb", {7'd0, ack}, 8'h00);
    i2c_stop();
    chk("t4_ptr_wr", o_ptr, 8'h01);
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'hFF, ack);
    i2c_start();
    wr_byte(8'hA1, ack);
    rd_byte(1'b0, d); chk("t4_rd_ff", d, 8'hAA);
    rd_byte(1'b1, d); chk("t4_rd_00", d, 8'hBB);
    i2c_stop();
    chk("t4_ptr_rd", o_ptr, 8'h01);

    // reset while the target drives bit7=0 of 0x11
    i2c_start();
    wr_byte(8'hA0, ack);
    wr_byte(8'h10, ack);
    i2c_start();
    wr_byte(8'hA1, ack);
    chk("t5_sda_low", {7'd0, o_i2c_sda}, 8'h00);
    chk("t5_ptr_pre", o_ptr, 8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_sda_rel", {7'd0, o_i2c_sda}, 8'h01);
    chk("t5_busy", {7'd0, o_busy}, 8'h00);
    chk("t5_ptr", o_ptr, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    i2c_stop();

`ifdef I2C_TGT_AXIS_EN
    begin
      logic       seen;
      logic [7:0] ld;
      seen = 1'b0;
      ld = 8'hFF;
      i2c_start();
      wr_byte(8'hA0, ack);
      wr_byte(8'h20, ack);
      wr_byte(8'h5A, ack); chk("t6_ack_5a", {7'd0, ack}, 8'h00);
      chk("t6_tvalid", {7'd0, tvalid}, 8'h01);
      chk("t6_tdata", tdata, 8'h5A);
      wr_byte(8'h6B, ack); chk("t6_nack_6b", {7'd0, ack}, 8'h01);
      chk("t6_ptr", o_ptr, 8'h21);
      tready = 1'b1;
      repeat (3) @(negedge clk);
      chk("t6_drained", {7'd0, tvalid}, 8'h00);
      i2c_stop();
      for (int i = 0; i < 40 && !seen; i++) begin
        @(negedge clk);
        if (tvalid && tlast) begin
          seen = 1'b1;
          ld = tdata;
        end
      end
      chk("t6_tlast", {7'd0, seen}, 8'h01);
      chk("t6_last_data", ld, 8'h00);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
